ps2_game_keys: RTL and testbench
================================

Name: ps2_game_keys

Overview:
- Upstream input stage for the game top level: sits between the PS/2 byte receiver and the player/bullet/controller logic.
- Consumes raw scan-code bytes (Set 2), strips E0/F0 prefixes and maintains held-key state for Left, Right, Fire and Restart.
- Produces clean level outputs, a one-shot fire pulse per physical press, and an active-low game reset.
- Replaces ad-hoc per-byte compares, which cannot handle prefix sequences or typematic repeat.

Parameters:
- TIMEOUT_CYCLES, 1000000, cycles a prefix may wait for its next byte before being discarded (20 ms at 50 MHz).
- CODE_LEFT, 8'h6B, scan code mapped to Left.
- CODE_RIGHT, 8'h74, scan code mapped to Right.
- CODE_FIRE, 8'h29, scan code mapped to Fire (space).
- CODE_RESTART, 8'h2D, scan code mapped to Restart (R).

Ports:
- CLOCK_50  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- byte_in  in  8  received PS/2 byte, valid only while byte_valid=1.
- byte_valid  in  1  single-cycle strobe, one per received byte.
- key_left  out  1  Left held.
- key_right  out  1  Right held.
- key_fire  out  1  Fire held.
- fire_pulse  out  1  one-cycle pulse on Fire make when Fire was not already held.
- move_left  out  1  key_left & ~key_right.
- move_right  out  1  key_right & ~key_left.
- game_reset_n  out  1  low while Restart held, else high.

Behaviour:
- Reset (async assert, sync release): state=IDLE; timeout counter=0; all held flags=0; fire_pulse=0; game_reset_n=1; move_*=0.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0 seen). Transitions occur only on cycles with byte_valid=1, except timeout.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - 00 or FF (overrun/error) -> clear all held flags, stay IDLE.
  - Any other byte -> make event for that code, stay IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - E0 -> stay EXT.
  - Any other byte -> make event, go to IDLE.
- BRK and EXT_BRK:
  - Any byte except E0/F0 -> break event for that code, go to IDLE.
  - E0/F0 -> protocol error: discard, go to IDLE, held flags unchanged.
- Key identity ignores the E0 prefix: E0 6B and 6B both mean Left, so keypad 4/6 also steer. Unmapped codes (including fake-shift E0 12 and E1 Pause sequences) change no flags.
- Make event: set the flag. Break event: clear the flag. Typematic repeat makes re-set an already-set flag, no other effect.
- fire_pulse:
  - Registered; asserted for exactly one cycle, the cycle after the byte_valid carrying a Fire make, only if key_fire was 0 before that make.
  - Repeat makes produce no pulse. A new press after a break pulses again.
- Latency: held flags, move_*, game_reset_n and fire_pulse all update on the clock edge following the byte_valid cycle (1 cycle). move_* are combinational from the registered flags.
- Timeout: a counter runs while in EXT/BRK/EXT_BRK and clears on every byte_valid or return to IDLE. Reaching TIMEOUT_CYCLES-1 forces IDLE with flags unchanged. The counter saturates and never wraps.
- byte_valid in consecutive cycles: each byte is processed in order; no bytes are dropped.
- Left and Right both held: key_left=key_right=1, move_left=move_right=0.
- Asserting reset mid-sequence (e.g. after F0) discards the prefix. The next byte is interpreted from IDLE.
- game_reset_n drives the rest of the game only. This block's own reset is the external `reset` port, so Restart never resets this block.

Test Plan:
- Bytes 29 -> pulse seen on 1 cycle, key_fire=1. Three further 29 bytes -> key_fire stays 1, no further fire_pulse. Then F0,29 -> key_fire=0. Then 29 -> fire_pulse again.
- E0,6B -> key_left=1, move_left=1. E0,74 -> move_left=0, move_right=0. E0,F0,6B -> move_right=1. E0,F0,74 -> all 0.
- 2D -> game_reset_n=0 one cycle after byte_valid. F0,2D -> game_reset_n=1. Block state is unaffected throughout.
- F0, then idle for TIMEOUT_CYCLES (use TIMEOUT_CYCLES=16) -> state returns to IDLE. Following 6B is a make: key_left=1, not a break.
- Hold Left and Fire, then send FF -> all flags 0, fire_pulse=0. Unmapped 1C make/break -> no output change.
- Assert reset after E0,F0 with Left held -> all outputs at reset values. Release, send 6B -> key_left=1.

Source files
------------

// File: rtl/ps2_game_keys.sv
// ps2_game_keys: turns raw PS/2 Set-2 scan-code bytes into held-key levels for the game.
//   CLOCK_50     in  system clock, rising edge
//   reset        in  asynchronous active-low reset
//   byte_in      in  [7:0] received byte, valid while byte_valid=1
//   byte_valid   in  one-cycle strobe per received byte
//   key_left     out Left held
//   key_right    out Right held
//   key_fire     out Fire held
//   fire_pulse   out one-cycle pulse on a fresh Fire press
//   move_left    out Left held and Right not held
//   move_right   out Right held and Left not held
//   game_reset_n out low while Restart held
module ps2_game_keys #(
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  CODE_LEFT      = 8'h6B,
    parameter logic [7:0]  CODE_RIGHT     = 8'h74,
    parameter logic [7:0]  CODE_FIRE      = 8'h29,
    parameter logic [7:0]  CODE_RESTART   = 8'h2D
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       key_left,
    output logic       key_right,
    output logic       key_fire,
    output logic       fire_pulse,
    output logic       move_left,
    output logic       move_right,
    output logic       game_reset_n
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    // Flag vector layout: {restart, fire, right, left}
    localparam int FL = 0, FR = 1, FF = 2, FS = 3;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      flags_q, flags_d;
    logic            pulse_q, pulse_d;
    logic [3:0]      hit;
    logic            is_prefix, clr, make_ev, break_ev;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            flags_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
            pulse_q <= pulse_d;
        end
    end

    // Next state: bytes take priority over an expiring prefix.
    always_comb begin
        state_d = state_q;
        if (byte_valid) begin
            case (state_q)
                IDLE:    state_d = byte_in == 8'hE0 ? EXT : byte_in == 8'hF0 ? BRK : IDLE;
                EXT:     state_d = byte_in == 8'hF0 ? EXT_BRK : byte_in == 8'hE0 ? EXT : IDLE;
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && cnt_q == CNT_MAX) begin
            state_d = IDLE;
        end
    end

    // Prefix age counter; saturates at the timeout value.
    always_comb begin
        cnt_d = (byte_valid || state_q == IDLE) ? '0 :
                (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    // Event decode and flag update. Key identity ignores E0, so only the code byte is compared.
    always_comb begin
        hit       = {byte_in == CODE_RESTART, byte_in == CODE_FIRE,
                     byte_in == CODE_RIGHT, byte_in == CODE_LEFT};
        is_prefix = byte_in == 8'hE0 || byte_in == 8'hF0;
        clr       = byte_valid && state_q == IDLE && (byte_in == 8'h00 || byte_in == 8'hFF);
        make_ev   = byte_valid && !is_prefix && !clr && (state_q == IDLE || state_q == EXT);
        break_ev  = byte_valid && !is_prefix && (state_q == BRK || state_q == EXT_BRK);
        flags_d   = clr ? 4'b0 :
                    make_ev ? flags_q | hit :
                    break_ev ? flags_q & ~hit : flags_q;
        pulse_d   = make_ev && hit[FF] && !flags_q[FF];
    end

    always_comb begin
        key_left     = flags_q[FL];
        key_right    = flags_q[FR];
        key_fire     = flags_q[FF];
        fire_pulse   = pulse_q;
        move_left    = flags_q[FL] & ~flags_q[FR];
        move_right   = flags_q[FR] & ~flags_q[FL];
        game_reset_n = ~flags_q[FS];
    end
endmodule

// File: tb/tb_ps2_game_keys.sv
// tb_ps2_game_keys: self-checking bench for ps2_game_keys against a byte-level key model.
module tb_ps2_game_keys;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       key_left, key_right, key_fire, fire_pulse, move_left, move_right, game_reset_n;

    int total = 0;
    int bad   = 0;

    // Model: which keys are held, whether E0/F0 prefixes are pending, and how long the prefix has waited.
    bit m_l, m_r, m_f, m_rs, m_p, m_ext, m_brk;
    int m_gap;

    ps2_game_keys #(.TIMEOUT_CYCLES(T)) dut (
        .CLOCK_50(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .key_left(key_left), .key_right(key_right), .key_fire(key_fire),
        .fire_pulse(fire_pulse), .move_left(move_left), .move_right(move_right),
        .game_reset_n(game_reset_n)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] obs();
        return {key_left, key_right, key_fire, fire_pulse, move_left, move_right, game_reset_n};
    endfunction

    function automatic logic [6:0] expv();
        return {m_l, m_r, m_f, m_p, m_l & ~m_r, m_r & ~m_l, ~m_rs};
    endfunction

    task automatic model_reset();
        {m_l, m_r, m_f, m_rs, m_p, m_ext, m_brk} = '0;
        m_gap = 0;
    endtask

    task automatic key_event(input logic [7:0] b, input bit mk);
        case (b)
            8'h6B: m_l = mk;
            8'h74: m_r = mk;
            8'h2D: m_rs = mk;
            8'h29: begin
                if (mk && !m_f) m_p = 1;
                m_f = mk;
            end
            default: ;
        endcase
    endtask

    task automatic model_step(input logic v, input logic [7:0] b);
        m_p = 0;
        if (v) begin
            m_gap = 0;
            if (m_brk) begin
                if (b != 8'hE0 && b != 8'hF0) key_event(b, 0);
                m_ext = 0; m_brk = 0;
            end else if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
            else if (!m_ext && (b == 8'h00 || b == 8'hFF)) {m_l, m_r, m_f, m_rs} = '0;
            else begin
                key_event(b, 1);
                m_ext = 0;
            end
        end else if (m_ext || m_brk) begin
            m_gap++;
            if (m_gap >= T) begin m_ext = 0; m_brk = 0; m_gap = 0; end
        end
    endtask

    // One clock cycle of stimulus; outputs are stable when it returns.
    task automatic cyc(input logic v, input logic [7:0] b);
        byte_in = b;
        byte_valid = v;
        @(posedge clk);
        #1;
        model_step(v, b);
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (obs() !== 7'b0000001) begin bad++; $display("FAIL reset_values got=%b want=%b", obs(), 7'b0000001); end
        reset = 1'b1;
        cyc(0, 8'h00);
        total++;
        if (obs() !== expv()) begin bad++; $display("FAIL reset_release got=%b want=%b", obs(), expv()); end
    endtask

    task automatic test_fire();
        logic [7:0] s [7] = '{8'h29, 8'h29, 8'h29, 8'h29, 8'hF0, 8'h29, 8'h29};
        int pulses = 0;
        foreach (s[i]) begin
            cyc(1, s[i]);
            if (i < 4) pulses += fire_pulse;
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL fire step%0d got=%b want=%b", i, obs(), expv()); end
        end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL fire_repeat_pulses got=%0d want=1", pulses); end
        total++;
        if (fire_pulse !== 1'b1 || key_fire !== 1'b1) begin
            bad++; $display("FAIL fire_repress got=%b%b want=11", fire_pulse, key_fire);
        end
        cyc(1, 8'hF0); cyc(1, 8'h29);
    endtask

    task automatic test_steer();
        logic [7:0] s [10] = '{8'hE0, 8'h6B, 8'hE0, 8'h74, 8'hE0, 8'hF0, 8'h6B, 8'hE0, 8'hF0, 8'h74};
        foreach (s[i]) begin
            cyc(1, s[i]);
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL steer step%0d got=%b want=%b", i, obs(), expv()); end
            if (i == 1) begin
                total++;
                if ({key_left, move_left} !== 2'b11) begin bad++; $display("FAIL steer_left got=%b want=11", {key_left, move_left}); end
            end
            if (i == 3) begin
                total++;
                if ({move_left, move_right} !== 2'b00) begin bad++; $display("FAIL steer_both got=%b want=00", {move_left, move_right}); end
            end
            if (i == 6) begin
                total++;
                if (move_right !== 1'b1) begin bad++; $display("FAIL steer_right got=%b want=1", move_right); end
            end
        end
        total++;
        if (obs() !== 7'b0000001) begin bad++; $display("FAIL steer_release got=%b want=0000001", obs()); end
    endtask

    task automatic test_restart();
        cyc(1, 8'h2D);
        total++;
        if (game_reset_n !== 1'b0 || obs() !== expv()) begin bad++; $display("FAIL restart_make got=%b want=%b", obs(), expv()); end
        cyc(1, 8'h6B);
        total++;
        if (key_left !== 1'b1) begin bad++; $display("FAIL restart_block_alive got=%b want=1", key_left); end
        cyc(1, 8'hF0); cyc(1, 8'h2D);
        total++;
        if (game_reset_n !== 1'b1 || obs() !== expv()) begin bad++; $display("FAIL restart_break got=%b want=%b", obs(), expv()); end
        cyc(1, 8'hF0); cyc(1, 8'h6B);
    endtask

    task automatic test_timeout();
        cyc(1, 8'h6B);
        cyc(1, 8'hF0);
        repeat (T - 1) cyc(0, 8'h00);
        cyc(1, 8'h6B);
        total++;
        if (key_left !== 1'b0 || obs() !== expv()) begin bad++; $display("FAIL timeout_just_inside got=%b want=%b", obs(), expv()); end
        cyc(1, 8'hF0);
        repeat (T) cyc(0, 8'h00);
        cyc(1, 8'h6B);
        total++;
        if (key_left !== 1'b1 || obs() !== expv()) begin bad++; $display("FAIL timeout_expired got=%b want=%b", obs(), expv()); end
        cyc(1, 8'hE0); cyc(1, 8'hF0);
        repeat (T + 5) cyc(0, 8'h00);
        cyc(1, 8'h29);
        total++;
        if (obs() !== expv()) begin bad++; $display("FAIL timeout_ext_brk got=%b want=%b", obs(), expv()); end
    endtask

    task automatic test_error_clear();
        logic [7:0] s [10] = '{8'h6B, 8'h29, 8'hFF, 8'h1C, 8'hF0, 8'h1C, 8'h74, 8'hE0, 8'h00, 8'h00};
        foreach (s[i]) begin
            cyc(1, s[i]);
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL errclr step%0d got=%b want=%b", i, obs(), expv()); end
            if (i == 2) begin
                total++;
                if (obs() !== 7'b0000001) begin bad++; $display("FAIL errclr_ff got=%b want=0000001", obs()); end
            end
        end
    endtask

    task automatic test_reset_mid();
        cyc(1, 8'h6B); cyc(1, 8'hE0); cyc(1, 8'hF0);
        #2 reset = 1'b0;
        #1;
        model_reset();
        total++;
        if (obs() !== 7'b0000001) begin bad++; $display("FAIL midreset_async got=%b want=0000001", obs()); end
        @(posedge clk); #1;
        reset = 1'b1;
        cyc(0, 8'h00);
        cyc(1, 8'h6B);
        total++;
        if (key_left !== 1'b1 || obs() !== expv()) begin bad++; $display("FAIL midreset_make got=%b want=%b", obs(), expv()); end
    endtask

    task automatic test_random();
        logic [7:0] pool [11] = '{8'h6B, 8'h74, 8'h29, 8'h2D, 8'hE0, 8'hF0, 8'hF0, 8'h00, 8'hFF, 8'h1C, 8'h12};
        logic [7:0] b;
        int n;
        for (int k = 0; k < 500; k++) begin
            n = ($urandom_range(0, 15) == 0) ? $urandom_range(T - 2, T + 2) : $urandom_range(0, 2);
            for (int j = 0; j < n; j++) begin
                cyc(0, 8'($urandom));
                total++;
                if (obs() !== expv()) begin bad++; $display("FAIL random_idle k=%0d got=%b want=%b", k, obs(), expv()); end
            end
            b = ($urandom_range(0, 11) == 11) ? 8'($urandom) : pool[$urandom_range(0, 10)];
            cyc(1, b);
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL random_byte k=%0d b=%h got=%b want=%b", k, b, obs(), expv()); end
        end
    endtask

    initial begin
        test_reset();
        test_fire();
        test_steer();
        test_restart();
        test_timeout();
        test_error_clear();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
